// File: rtl/rca_pkg.sv
// Shared constants and FSM state type for the sequential ripple-carry adder/subtractor.
package rca_pkg;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/rca_seq_if.sv
// Operand/result bundle for rca_seq. Both sides use valid/ready: a transfer happens on a rising
// edge where valid and ready are both high; the producer holds its data until that edge.
interface rca_seq_if
  import rca_pkg::*;
#(
  parameter int WIDTH = 16
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             cin;
  logic             mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH:0]   sum;
  logic             ovf;
  state_t           state;

  modport master (
    output in_valid, x, y, cin, mode, out_ready,
    input  in_ready, out_valid, sum, ovf, state
  );

  modport slave (
    input  in_valid, x, y, cin, mode, out_ready,
    output in_ready, out_valid, sum, ovf, state
  );

endinterface

// File: rtl/rca_seg.sv
// Combinational SEG-bit ripple chain built from full-adder cells.
// c_msb is the carry into the top bit, used for signed overflow detection.
module rca_fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module rca_seg #(
  parameter int SEG = 4
) (
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  input  logic           ci,
  output logic [SEG-1:0] s,
  output logic           co,
  output logic           c_msb
);

  logic [SEG:0] c;

  assign c[0] = ci;

  for (genvar i = 0; i < SEG; i++) begin : g_fa
    rca_fa u_fa (
      .a  (a[i]),
      .b  (b[i]),
      .ci (c[i]),
      .s  (s[i]),
      .co (c[i+1])
    );
  end

  assign co    = c[SEG];
  assign c_msb = c[SEG-1];

endmodule

// File: rtl/rca_seq.sv
// Multi-cycle add/sub: one SEG-bit slice per clock from the LSB, carry held in a flop
// between slices. Operands are captured on accept, so inputs may change during CALC.
module rca_seq
  import rca_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SEG   = 4
) (
  input  logic          clk,
  input  logic          rst,
  rca_seq_if.slave      bus
);

  localparam int NSEG = (SEG >= 1) ? (WIDTH / SEG) : 1;
  localparam int KW   = (NSEG > 1) ? $clog2(NSEG) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NSEG - 1);

  if ((SEG < 1) || (WIDTH % SEG != 0)) begin : g_bad_params
    $fatal(1, "rca_seq: WIDTH (%0d) must be a positive multiple of SEG (%0d)", WIDTH, SEG);
  end

  state_t           state, next_state;
  logic [WIDTH-1:0] xr, yr;
  logic             carry;
  logic [KW-1:0]    k;
  logic [WIDTH:0]   sum_r;
  logic             ovf_r;

  logic [SEG-1:0]   seg_a, seg_b, seg_s;
  logic             seg_co, seg_c_msb;

  // Slice mux: only one adder slice exists; k walks it across the operands.
  assign seg_a = xr[int'(k)*SEG +: SEG];
  assign seg_b = yr[int'(k)*SEG +: SEG];

  rca_seg #(.SEG(SEG)) u_seg (
    .a     (seg_a),
    .b     (seg_b),
    .ci    (carry),
    .s     (seg_s),
    .co    (seg_co),
    .c_msb (seg_c_msb)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (bus.in_valid)  next_state = CALC;
      CALC:    if (k == K_LAST)   next_state = DONE;
      DONE:    if (bus.out_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      xr    <= '0;
      yr    <= '0;
      carry <= 1'b0;
      k     <= '0;
      sum_r <= '0;
      ovf_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            xr    <= bus.x;
            // Subtraction is x + ~y + 1: invert y here and seed the carry with 1.
            yr    <= (bus.mode == MODE_SUB) ? ~bus.y : bus.y;
            carry <= (bus.mode == MODE_SUB) ? 1'b1 : bus.cin;
            k     <= '0;
          end
        end
        CALC: begin
          sum_r[int'(k)*SEG +: SEG] <= seg_s;
          carry                     <= seg_co;
          if (k == K_LAST) begin
            sum_r[WIDTH] <= seg_co;
            ovf_r        <= seg_c_msb ^ seg_co;
            k            <= '0;
          end else begin
            k <= k + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Handshake outputs decode state only; rst masks in_ready while held.
  assign bus.in_ready  = (state == IDLE) && !rst;
  assign bus.out_valid = (state == DONE);
  assign bus.sum       = sum_r;
  assign bus.ovf       = ovf_r;
  assign bus.state     = state;

endmodule

// File: tb/tb_rca_seq.sv
// Directed bench for rca_seq: main checks on SEG=4, plus SEG=16 and SEG=1 instances
// sharing the same stimulus for the latency/parameter sweep.
module tb_rca_seq;
  import rca_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        cin = 1'b0;
  logic        mode = 1'b0;
  logic        out_ready = 1'b0;
  logic [15:0] x = '0;
  logic [15:0] y = '0;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  rca_seq_if #(.WIDTH(16)) b4 ();
  rca_seq_if #(.WIDTH(16)) b16 ();
  rca_seq_if #(.WIDTH(16)) b1 ();

  assign b4.in_valid  = in_valid;  assign b4.x  = x;  assign b4.y  = y;
  assign b4.cin       = cin;       assign b4.mode  = mode;  assign b4.out_ready  = out_ready;
  assign b16.in_valid = in_valid;  assign b16.x = x;  assign b16.y = y;
  assign b16.cin      = cin;       assign b16.mode = mode;  assign b16.out_ready = out_ready;
  assign b1.in_valid  = in_valid;  assign b1.x  = x;  assign b1.y  = y;
  assign b1.cin       = cin;       assign b1.mode  = mode;  assign b1.out_ready  = out_ready;

  rca_seq #(.WIDTH(16), .SEG(4))  u4  (.clk(clk), .rst(rst), .bus(b4));
  rca_seq #(.WIDTH(16), .SEG(16)) u16 (.clk(clk), .rst(rst), .bus(b16));
  rca_seq #(.WIDTH(16), .SEG(1))  u1  (.clk(clk), .rst(rst), .bus(b1));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Called #1 after a rising edge; returns #1 after the accepting edge.
  task automatic accept(input logic m, input logic [15:0] a_v, input logic [15:0] b_v,
                        input logic c_v);
    int n = 0;
    while (!b4.in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("accept_wait_timeout", 32'(n < 50), 32'd1);
    mode = m; x = a_v; y = b_v; cin = c_v; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    x = 16'($urandom); y = 16'($urandom); cin = ~c_v; mode = ~m;
  endtask

  // Latency counts the accepting edge as edge 1.
  task automatic wait_done(output int lat);
    lat = 1;
    while (!b4.out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic do_op(input string tag, input logic m, input logic [15:0] a_v,
                       input logic [15:0] b_v, input logic c_v,
                       input logic [16:0] exp_sum, input logic exp_ovf);
    int lat;
    accept(m, a_v, b_v, c_v);
    wait_done(lat);
    chk({tag, "_lat"}, 32'(lat), 32'd5);
    chk({tag, "_sum"}, 32'(b4.sum), 32'(exp_sum));
    chk({tag, "_ovf"}, 32'(b4.ovf), 32'(exp_ovf));
    release_out();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  lat, l4, l16, l1;
    logic hold_sum_ok, seen_valid;
    logic [16:0] held;

    #2;
    chk("rst_in_ready", 32'(b4.in_ready), 32'd0);
    chk("rst_out_valid", 32'(b4.out_valid), 32'd0);
    chk("rst_sum", 32'(b4.sum), 32'd0);
    chk("rst_ovf", 32'(b4.ovf), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", 32'(b4.in_ready), 32'd1);

    do_op("add_carry", MODE_ADD, 16'hFFFF, 16'h0001, 1'b0, 17'h10000, 1'b0);
    do_op("sub_borrow", MODE_SUB, 16'h0005, 16'h0007, 1'b0, 17'h0FFFE, 1'b0);
    do_op("add_ovf", MODE_ADD, 16'h7FFF, 16'h0001, 1'b0, 17'h08000, 1'b1);
    do_op("sub_ovf", MODE_SUB, 16'h8000, 16'h0001, 1'b0, 17'h17FFF, 1'b1);
    do_op("sub_cin_ignored", MODE_SUB, 16'h0007, 16'h0005, 1'b1, 17'h10002, 1'b0);
    do_op("add_cin", MODE_ADD, 16'h00FF, 16'h0F00, 1'b1, 17'h01000, 1'b0);

    // Backpressure: result held while in_valid pulses with other operands.
    accept(MODE_ADD, 16'h1111, 16'h2222, 1'b0);
    wait_done(lat);
    chk("bp_lat", 32'(lat), 32'd5);
    held = b4.sum;
    chk("bp_sum", 32'(held), 32'h03333);
    hold_sum_ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; mode = 1'($urandom);
      x = 16'($urandom); y = 16'($urandom); cin = 1'($urandom);
      @(posedge clk); #1;
      chk("bp_sum_stable", 32'(b4.sum), 32'h03333);
      chk("bp_ovf_stable", 32'(b4.ovf), 32'd0);
      chk("bp_in_ready", 32'(b4.in_ready), 32'd0);
      chk("bp_out_valid", 32'(b4.out_valid), 32'd1);
    end
    in_valid = 1'b0;
    release_out();
    chk("bp_release_in_ready", 32'(b4.in_ready), 32'd1);
    chk("bp_release_out_valid", 32'(b4.out_valid), 32'd0);
    @(posedge clk); #1;
    chk("bp_no_second_accept", 32'(b4.in_ready), 32'd1);

    // Reset after two CALC edges.
    accept(MODE_ADD, 16'h1234, 16'h4321, 1'b1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("mid_pre_rst_state", 32'(b4.state), 32'(CALC));
    rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", 32'(b4.out_valid), 32'd0);
    chk("mid_rst_sum", 32'(b4.sum), 32'd0);
    chk("mid_rst_ovf", 32'(b4.ovf), 32'd0);
    chk("mid_rst_in_ready", 32'(b4.in_ready), 32'd0);
    chk("mid_rst_state", 32'(b4.state), 32'(IDLE));
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("mid_rst_release_in_ready", 32'(b4.in_ready), 32'd1);
    seen_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      seen_valid |= b4.out_valid;
    end
    chk("mid_rst_no_output", 32'(seen_valid), 32'd0);
    do_op("reissue", MODE_ADD, 16'h1234, 16'h4321, 1'b1, 17'h05556, 1'b0);

    // Parameter sweep: all three instances take the same op from a clean reset.
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b0;
    mode = MODE_ADD; x = 16'hFFFF; y = 16'hFFFF; cin = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; x = '0; y = '0; cin = 1'b0;
    l4 = 0; l16 = 0; l1 = 0;
    for (int n = 2; n <= 30; n++) begin
      @(posedge clk); #1;
      if (b4.out_valid  && l4  == 0) l4  = n;
      if (b16.out_valid && l16 == 0) l16 = n;
      if (b1.out_valid  && l1  == 0) l1  = n;
    end
    chk("sweep_seg4_lat", 32'(l4), 32'd5);
    chk("sweep_seg16_lat", 32'(l16), 32'd2);
    chk("sweep_seg1_lat", 32'(l1), 32'd17);
    chk("sweep_seg4_sum", 32'(b4.sum), 32'h1FFFF);
    chk("sweep_seg16_sum", 32'(b16.sum), 32'h1FFFF);
    chk("sweep_seg1_sum", 32'(b1.sum), 32'h1FFFF);
    chk("sweep_seg16_ovf", 32'(b16.ovf), 32'd0);
    chk("sweep_seg1_ovf", 32'(b1.ovf), 32'd0);
    release_out();
    chk("sweep_seg1_idle", 32'(b1.in_ready), 32'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/rca_seq.md
# rca_seq

Parametrised, multi-cycle ripple-carry adder/subtractor. It processes WIDTH-bit operands one SEG-bit slice per clock, starting from the least-significant slice, and holds the inter-slice carry in a flop. Operands enter and results leave through valid/ready handshakes. The block is the successor to the fixed 4-bit combinational ripple adder in the arithmetic library. It serves datapaths that need wide add/sub at low area and can tolerate multi-cycle latency.

## Interface
Parameters:
- WIDTH, 16, operand width in bits; must be a multiple of SEG.
- SEG, 4, slice width added per cycle; 1 ≤ SEG ≤ WIDTH.
- NSEG (localparam), WIDTH/SEG, number of CALC cycles.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  operands and mode valid.
- in_ready  out  1  block can accept a new operation.
- x  in  WIDTH  operand A.
- y  in  WIDTH  operand B.
- cin  in  1  carry-in. Used only in ADD mode.
- mode  in  1  0 = ADD (x+y+cin), 1 = SUB (x−y, computed as x+~y+1).
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- sum  out  WIDTH+1  result. sum[WIDTH] is carry-out; in SUB mode it is 1 when there is no borrow.
- ovf  out  1  signed two's-complement overflow of sum[WIDTH-1:0].

## Operation
- FSM states: IDLE, CALC, DONE.
- **IDLE**
  - in_ready=1.
  - On in_valid&&in_ready: capture x; capture y, or ~y when mode=SUB; load the carry flop with cin (ADD) or 1 (SUB); set slice index k=0; go to CALC.
- **CALC**
  - in_ready=0.
  - Each cycle, add slice k of x and y with the carry flop.
  - Write the SEG-bit result into sum[k*SEG +: SEG] and the slice carry-out into the carry flop.
  - k increments each cycle. When k=NSEG−1, also:
    - write the carry-out to sum[WIDTH];
    - set ovf = (carry into bit WIDTH−1) XOR (carry out of bit WIDTH−1);
    - go to DONE.
- **DONE**
  - out_valid=1; sum and ovf are held stable.
  - On out_ready go to IDLE. out_valid falls and in_ready rises in the same cycle.
  - A new accept is possible one cycle after the output handshake. There is no overlap between operations.
- in_valid while not in IDLE is ignored and does not corrupt the operation in progress.
- Captured operands are held internally. x, y, cin and mode may change freely after the accepting edge.
- Arithmetic is modulo 2^(WIDTH+1) in sum. No saturation.
- Reset:
  - Asserting rst at any time, including mid-CALC or in DONE, immediately forces the following:
    - state=IDLE, k=0, carry=0;
    - sum=0, ovf=0, out_valid=0;
    - in_ready=1 once rst deasserts.
  - The aborted operation is discarded and produces no output.

## Timing
- Reset values: out_valid=0, sum=0, ovf=0, in_ready=1 (it is 0 while rst is high).
- Latency: out_valid rises NSEG+1 rising edges after the accepting edge (1 edge into CALC, then NSEG CALC edges).
  - Default parameters: 5 edges.
  - SEG=WIDTH: 2 edges.
- Throughput with out_ready held high: one result every NSEG+2 cycles.
- in_ready and out_valid are decoded directly from the state register, with no combinational path from inputs.
- Critical path: SEG full-adder carry chain plus the slice mux. It is independent of WIDTH.

## Structure
- Package rca_pkg holds:
  - MODE_ADD=1'b0 and MODE_SUB=1'b1;
  - the FSM state enum (IDLE, CALC, DONE).
- Sub-module rca_seg: a combinational SEG-bit ripple chain of FA instances.
  - Inputs: a, b, ci.
  - Outputs: s, co, and c_msb (the carry into the top bit, needed for ovf).
  - rca_seq instantiates exactly one rca_seg and muxes slice k into it.
- Elaboration-time check: WIDTH % SEG == 0 and SEG ≥ 1; otherwise a fatal error.

## Test plan
All scenarios use WIDTH=16, SEG=4 unless stated.
- ADD, x=0xFFFF, y=0x0001, cin=0 → sum=0x10000, ovf=0. out_valid rises exactly 5 edges after accept.
- SUB, x=0x0005, y=0x0007 → sum=0x0FFFE (sum[16]=0, borrow), ovf=0.
- Signed overflow:
  - ADD, x=0x7FFF, y=0x0001 → sum=0x08000, ovf=1.
  - SUB, x=0x8000, y=0x0001 → sum=0x17FFF, ovf=1.
- Backpressure: hold out_ready=0 for 10 cycles in DONE while pulsing in_valid with other operands → sum and ovf stay stable, in_ready=0, and the second operation is not accepted. Release out_ready → in_ready=1 on the next cycle.
- Reset mid-op: start ADD 0x1234+0x4321, cin=1, and assert rst after 2 CALC edges → outputs clear immediately, no out_valid. Reissue the same operation → sum=0x05556.
- Parameter sweep: with SEG=16, ADD 0xFFFF+0xFFFF, cin=1 → sum=0x1FFFF, latency 2 edges. With SEG=1, the same operation gives latency 17 edges and the same result.
